td50_tap_monitor: RTL

- Synchronous consumer of a TD50 tapped delay line: watches the launch pulse (trig) and the five active-low tap outputs (10/20/30/40/50 ns).
- Checks that the taps fire in order with in-window spacing, measures the trig-to-last-tap span, and counts good sequences.
- Reports sticky errors, and sits between the delay-line timing chain and the FPGA clock-domain status/debug logic.

---
 rtl/td50_tap_monitor_if.sv | 17 +
 rtl/td50_tap_monitor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/td50_tap_monitor_if.sv
// td50_tap_monitor_if: launch/tap inputs and status outputs of the TD50 tap monitor
interface td50_tap_monitor_if #(
  parameter int CNT_W = 8
);
  logic             trig;
  logic [4:0]       tap_n;
  logic             clr_err;
  logic [2:0]       gap_sel;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] span;
  logic [15:0]      seq_count;
  logic [3:0]       err;
  logic [CNT_W-1:0] gap_out;
  modport master (output trig, tap_n, clr_err, gap_sel, input busy, done, span, seq_count, err, gap_out);
  modport slave (input trig, tap_n, clr_err, gap_sel, output busy, done, span, seq_count, err, gap_out);
endinterface

// File: rtl/td50_tap_monitor.sv
// td50_tap_monitor: checks TD50 tap order/spacing, measures span, counts good sequences; TD_MON_GAPLOG_EN adds per-tap gap log
module td50_tap_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int MIN_GAP     = 1,
  parameter int MAX_GAP     = 4,
  parameter int TIMEOUT     = 16
) (
  input logic               clk,
  input logic               reset_n,
  td50_tap_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;
  localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  logic [SYNC_STAGES-1:0]      trig_sync_q;
  logic [SYNC_STAGES-1:0][4:0] tap_sync_q;
  logic                        trig_prev_q;
  logic [4:0]                  tap_prev_q;
  state_t                      state_q, state_d;
  logic [2:0]                  exp_q, exp_d;
  logic [CNT_W-1:0]            gap_q, gap_d, span_cnt_q, span_cnt_d, span_q;
  logic [15:0]                 seq_count_q;
  logic [3:0]                  err_q, err_set;
  logic                        trig_s, trig_rise, restart, accept;
  logic [4:0]                  tap_s, tap_fall, exp_oh;
  logic [CNT_W-1:0]            gap_inc, span_inc;
  assign trig_s    = trig_sync_q[SYNC_STAGES-1];
  assign tap_s     = tap_sync_q[SYNC_STAGES-1];
  assign trig_rise = trig_s & ~trig_prev_q;
  assign tap_fall  = ~tap_s & tap_prev_q;
  // sequence checker: gap is judged including the current cycle, so adjacent-cycle events measure 1
  always_comb begin
    exp_oh     = 5'b1 << exp_q;
    gap_inc    = &gap_q ? gap_q : gap_q + 1'b1;
    span_inc   = &span_cnt_q ? span_cnt_q : span_cnt_q + 1'b1;
    state_d    = state_q;
    exp_d      = exp_q;
    gap_d      = state_q == WAIT ? gap_inc : gap_q;
    span_cnt_d = state_q == WAIT ? span_inc : span_cnt_q;
    err_set    = '0;
    restart    = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: if (trig_rise) begin
        state_d = WAIT;
        restart = 1'b1;
      end
      WAIT: if (trig_rise) begin
        err_set[3] = 1'b1;
        restart    = 1'b1;
      end else if (|(tap_fall & ~exp_oh)) begin
        err_set[0] = 1'b1;
        state_d    = ERR;
      end else if (|(tap_fall & exp_oh)) begin
        if (gap_inc < MIN_G) begin
          err_set[1] = 1'b1;
          state_d    = ERR;
        end else if (gap_inc > MAX_G) begin
          err_set[2] = 1'b1;
          state_d    = ERR;
        end else begin
          accept  = 1'b1;
          gap_d   = '0;
          exp_d   = exp_q + 3'd1;
          state_d = exp_q == 3'd4 ? DONE : WAIT;
        end
      end else if (gap_inc >= TMO) begin
        err_set[2] = 1'b1;
        state_d    = ERR;
      end
      DONE: state_d = IDLE;
      default: state_d = (&tap_s && !trig_s) ? IDLE : ERR;
    endcase
    if (restart) begin
      exp_d      = '0;
      gap_d      = '0;
      span_cnt_d = '0;
    end
  end
  // synchronizers, edge detect, FSM and status registers; a same-cycle error set beats clr_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync_q <= '0;
      tap_sync_q  <= '1;
      trig_prev_q <= 1'b0;
      tap_prev_q  <= '1;
      state_q     <= IDLE;
      exp_q       <= '0;
      gap_q       <= '0;
      span_cnt_q  <= '0;
      span_q      <= '0;
      seq_count_q <= '0;
      err_q       <= '0;
    end else begin
      trig_sync_q <= {trig_sync_q[SYNC_STAGES-2:0], bus.trig};
      tap_sync_q  <= {tap_sync_q[SYNC_STAGES-2:0], bus.tap_n};
      trig_prev_q <= trig_s;
      tap_prev_q  <= tap_s;
      state_q     <= state_d;
      exp_q       <= exp_d;
      gap_q       <= gap_d;
      span_cnt_q  <= span_cnt_d;
      span_q      <= state_q == DONE ? span_cnt_q : bus.clr_err ? '0 : span_q;
      seq_count_q <= seq_count_q + {15'd0, state_q == DONE};
      err_q       <= (bus.clr_err ? 4'd0 : err_q) | err_set;
    end
  end
  assign bus.busy      = state_q == WAIT;
  assign bus.done      = state_q == DONE;
  assign bus.span      = span_q;
  assign bus.seq_count = seq_count_q;
  assign bus.err       = err_q;
`ifdef TD_MON_GAPLOG_EN
  logic [4:0][CNT_W-1:0] gaplog_q;
  logic [CNT_W-1:0]      gap_out_q;
  // per-tap gap log of the current/last sequence, read back one cycle after gap_sel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gaplog_q  <= '0;
      gap_out_q <= '0;
    end else begin
      if (restart) gaplog_q <= '0;
      else if (accept) gaplog_q[exp_q] <= gap_inc;
      gap_out_q <= bus.gap_sel < 3'd5 ? gaplog_q[bus.gap_sel] : '0;
    end
  end
  assign bus.gap_out = gap_out_q;
`else
  logic unused_gaplog;
  assign unused_gaplog = &{1'b0, bus.gap_sel, accept};
  assign bus.gap_out   = '0;
`endif
endmodule
